// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_sub_pkg;

  // ST 2'b11 is unused and recovers to ST_IDLE in the next-state logic.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Bit index counter width; WIDTH >= 2 always yields at least one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
// Latency: purely combinational.
// Backpressure: none.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin, with borrow-out and signed overflow.
// Latency: out_valid rises WIDTH edges after the accepting edge; issue interval >= WIDTH+2.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, stalls indefinitely.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             br_nxt;
  logic             cell_d;
  logic             a_msb;
  logic             b_msb;
  logic             accept;
  logic             last;

  // Single full-subtractor cell consumes the current LSBs and the running borrow.
  full_subtractor_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (br_nxt)
  );

  assign accept  = in_valid & (state == ST_IDLE);
  assign last    = (state == ST_RUN) && (cnt == CNT_LAST);
  assign res_nxt = {cell_d, res_sr[WIDTH-1:1]};

  // Handshake flags are pure functions of state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: in_ready  = 1'b1;
      ST_RUN:  busy      = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state: accept -> run WIDTH bits -> hold result until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Datapath: capture operands, shift one bit per RUN edge, latch result on the last bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            br     <= bin;
            cnt    <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          br     <= br_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            cnt  <= '0;
            diff <= res_nxt;
            bout <= br_nxt;
            // Overflow only possible when operand signs differ and result sign leaves a's.
            ovf  <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
